axis_uart_deframer: RTL and testbench
=====================================

# axis_uart_deframer

- Frame extractor on the receive path, directly downstream of the UART receiver's 8-bit AXI-Stream output.
- Hunts for a start-of-frame byte, reads a length byte, then forwards the payload as an AXI-Stream packet with `tlast` on the final payload byte.
- Verifies a trailing XOR checksum and flags a bad frame on `tuser` of that last beat.
- Aborts stalled frames after an inter-byte timeout.

## Interface
Parameters:
- `CLK_FREQ`, 27_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate; used only to derive the timeout.
- `MAX_LEN`, 255: largest legal LEN value (1..255).
- `TIMEOUT_BYTES`, 2: idle gap, in byte times, that aborts a frame. TIMEOUT_CYCLES = TIMEOUT_BYTES*10*CLK_FREQ/BAUD_RATE, integer division (4687 at defaults).

Ports:
- `clk_i`, in, 1: the single clock.
- `arst_i`, in, 1: reset, asynchronous and active-high.
- `s_axis_tdata`, in, 8: byte from the UART receiver.
- `s_axis_tvalid`, in, 1: input byte valid.
- `s_axis_tready`, out, 1: input byte accepted.
- `m_axis_tdata`, out, 8: payload byte.
- `m_axis_tvalid`, out, 1: output beat valid.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis_tlast`, out, 1: last payload byte of the frame.
- `m_axis_tuser`, out, 1: frame error; meaningful only when `tlast`=1.
- `frame_ok_o`, out, 1: one-cycle pulse when a frame completes with a good checksum.
- `frame_err_o`, out, 1: one-cycle pulse on bad LEN, bad checksum, or timeout.

## Operation
- Frame format: SOF (8'hA5), LEN, LEN payload bytes, CHK.
- A frame is good when LEN ^ payload[0] ^ … ^ payload[LEN-1] ^ CHK == 0.
- States:
  - HUNT: accepts every byte. SOF goes to LEN_S; any other byte is discarded silently.
  - LEN_S: accepts LEN.
    - LEN == 0 or LEN > MAX_LEN: pulse `frame_err_o`, go to HUNT, no output.
    - Otherwise load the remaining-byte counter with LEN, set acc = LEN, go to PAYLOAD.
  - PAYLOAD: on each accepted byte, acc ^= byte.
    - If the hold register is valid, its byte moves to the output register with `tlast`=0.
    - The new byte then enters the hold register.
    - Counter decrements; after the LEN-th byte, go to CHK.
  - CHK: on the accepted byte, the held byte moves to the output register with `tlast`=1 and `tuser` = ((acc ^ byte) != 0).
    - Pulse `frame_ok_o` or `frame_err_o` in that same cycle, clear the hold register, go to HUNT.
- The hold register exists so that `tlast` can be placed on the final payload byte before CHK has arrived.
- `s_axis_tready`:
  - Constant 1 in HUNT and LEN_S.
  - In PAYLOAD and CHK it equals (!m_axis_tvalid || m_axis_tready), so no byte is ever lost under backpressure.
- Timeout:
  - Counter clears on every accepted byte and in HUNT.
  - Increments in LEN_S, PAYLOAD and CHK on cycles with `s_axis_tvalid`=0.
  - When it reaches TIMEOUT_CYCLES: pulse `frame_err_o`.
    - If the hold register is valid, emit the held byte with `tlast`=1, `tuser`=1 as soon as the output register is free, then go to HUNT.
    - Otherwise go to HUNT immediately.
- A byte arriving in the same cycle as the timeout is ignored: `tready`=0 that cycle.

## Timing
- Reset values:
  - all `m_axis_*` outputs 0; `s_axis_tready` 0 during reset, 1 in HUNT after reset;
  - `frame_ok_o` = `frame_err_o` = 0;
  - state HUNT, hold register empty, counters 0.
- Reset asserted mid-frame discards the partial frame, including held and output beats. No `tlast` is emitted.
- Output is registered:
  - a beat is pushed in the cycle its trigger byte is accepted;
  - `m_axis_tvalid` rises the next cycle;
  - `m_axis_tdata`, `m_axis_tlast` and `m_axis_tuser` stay stable while `tvalid`=1 and `tready`=0.
- Payload byte k appears on the output one input-byte later (the hold stage). The last payload byte appears the cycle after CHK is accepted.
- Back-to-back frames are supported: SOF may be accepted in the cycle after CHK.

## Structure
- Package `axis_uart_pkg` (shared with the UART blocks): state enum `deframer_state_e` {HUNT, LEN_S, PAYLOAD, CHK} and constant `UART_SOF` = 8'hA5.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1); remaining-byte counter is 8 bits.
- Single module, no sub-modules.

## Test plan
- Input 00 FF A5 03 11 22 33 03 → output 11, 22, 33; `tlast` only on 33; `tuser`=0; one `frame_ok_o` pulse; 00 and FF produce nothing.
- Input A5 03 11 22 33 04 → same three beats, 33 with `tlast`=1 and `tuser`=1; one `frame_err_o` pulse.
- Input A5 00, then A5 01 7E 7F → `frame_err_o` pulse with no output; then a single beat 7E with `tlast`=1, `tuser`=0.
- Input A5 03 11 22, then idle 4687 cycles → 11 (`tlast`=0), then 22 (`tlast`=1, `tuser`=1), `frame_err_o` pulse, state back to HUNT. A following good frame passes cleanly.
- Hold `m_axis_tready`=0 for 50 cycles mid-frame with the source streaming → `s_axis_tready` drops and all bytes arrive in order with no loss. Stalled cycles count toward the timeout only while `s_axis_tvalid`=0.
- Assert `arst_i` after A5 03 11 22 → all outputs 0 immediately; after release, A5 01 7E 7F yields exactly one beat 7E.

Source files
------------

// File: rtl/axis_uart_pkg.sv
// Shared definitions for the UART receive-path blocks: deframer states,
// start-of-frame marker, output beat payload and timeout derivation.
package axis_uart_pkg;

    localparam logic [7:0] UART_SOF = 8'hA5;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN_S   = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } deframer_state_e;

    typedef struct packed {
        logic       user;
        logic       last;
        logic [7:0] data;
    } axis_beat_t;

    // Idle gap in clock cycles equal to 'bytes' UART characters of 10 bits each.
    function automatic int unsigned timeout_cycles(input int unsigned clk_freq,
                                                   input int unsigned baud_rate,
                                                   input int unsigned bytes);
        return (bytes * 10 * clk_freq) / baud_rate;
    endfunction

endpackage

// File: rtl/axis_uart_deframer.sv
// Extracts SOF/LEN/payload/CHK frames from a UART byte stream and forwards the
// payload as an AXI-Stream packet, flagging checksum errors and stalls on tuser.
module axis_uart_deframer
    import axis_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 27_000_000,
    parameter int unsigned BAUD_RATE     = 115_200,
    parameter int unsigned MAX_LEN       = 255,
    parameter int unsigned TIMEOUT_BYTES = 2
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       frame_ok_o,
    output logic       frame_err_o
);

    localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ, BAUD_RATE, TIMEOUT_BYTES);
    localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    deframer_state_e state;
    axis_beat_t      beat;
    logic [7:0]      remaining;
    logic [7:0]      acc;
    logic [7:0]      hold_data;
    logic            hold_valid;
    logic [TO_W-1:0] to_cnt;
    logic            aborting;

    logic out_free;
    logic timeout_hit;
    logic accept;
    logic len_bad;
    logic chk_bad;

    assign m_axis_tdata = beat.data;
    assign m_axis_tlast = beat.last;
    assign m_axis_tuser = beat.user;

    assign out_free    = !m_axis_tvalid || m_axis_tready;
    assign timeout_hit = (state != HUNT) && !aborting && (to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign accept      = s_axis_tvalid && s_axis_tready;
    assign len_bad     = (s_axis_tdata == 8'd0) || ({1'b0, s_axis_tdata} > 9'(MAX_LEN));
    assign chk_bad     = (acc ^ s_axis_tdata) != 8'd0;

    // Payload states only take a byte when the output register can absorb the held one.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!arst_i && !timeout_hit) begin
            case (state)
                HUNT, LEN_S:  s_axis_tready = 1'b1;
                PAYLOAD, CHK: s_axis_tready = out_free && !aborting;
                default:      s_axis_tready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state         <= HUNT;
            beat          <= '0;
            m_axis_tvalid <= 1'b0;
            remaining     <= '0;
            acc           <= '0;
            hold_data     <= '0;
            hold_valid    <= 1'b0;
            to_cnt        <= '0;
            aborting      <= 1'b0;
            frame_ok_o    <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;

            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            // Inter-byte idle counter; frozen once the abort is pending.
            if (state == HUNT || accept) begin
                to_cnt <= '0;
            end else if (!s_axis_tvalid && !aborting && !timeout_hit) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (timeout_hit) begin
                frame_err_o <= 1'b1;
                if (!hold_valid) begin
                    state <= HUNT;
                end else if (out_free) begin
                    beat          <= '{user: 1'b1, last: 1'b1, data: hold_data};
                    m_axis_tvalid <= 1'b1;
                    hold_valid    <= 1'b0;
                    state         <= HUNT;
                end else begin
                    aborting <= 1'b1;
                end
            end else if (aborting) begin
                if (out_free) begin
                    beat          <= '{user: 1'b1, last: 1'b1, data: hold_data};
                    m_axis_tvalid <= 1'b1;
                    hold_valid    <= 1'b0;
                    aborting      <= 1'b0;
                    state         <= HUNT;
                end
            end else if (accept) begin
                case (state)
                    HUNT: begin
                        if (s_axis_tdata == UART_SOF) begin
                            state <= LEN_S;
                        end
                    end
                    LEN_S: begin
                        if (len_bad) begin
                            frame_err_o <= 1'b1;
                            state       <= HUNT;
                        end else begin
                            remaining <= s_axis_tdata;
                            acc       <= s_axis_tdata;
                            state     <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        acc <= acc ^ s_axis_tdata;
                        if (hold_valid) begin
                            beat          <= '{user: 1'b0, last: 1'b0, data: hold_data};
                            m_axis_tvalid <= 1'b1;
                        end
                        hold_data  <= s_axis_tdata;
                        hold_valid <= 1'b1;
                        remaining  <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= CHK;
                        end
                    end
                    CHK: begin
                        beat          <= '{user: chk_bad, last: 1'b1, data: hold_data};
                        m_axis_tvalid <= 1'b1;
                        frame_ok_o    <= !chk_bad;
                        frame_err_o   <= chk_bad;
                        hold_valid    <= 1'b0;
                        state         <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_deframer.sv
// Directed bench for axis_uart_deframer: good, bad-checksum, bad-length,
// timeout, backpressure and mid-frame reset scenarios against hand-computed beats.
module tb_axis_uart_deframer;

    logic       clk;
    logic       arst_i;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       m_user;
    logic       frame_ok;
    logic       frame_err;

    int vectors    = 0;
    int miscompares = 0;
    int ok_cnt     = 0;
    int err_cnt    = 0;
    logic [9:0] q[$];

    axis_uart_deframer dut (
        .clk_i         (clk),
        .arst_i        (arst_i),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_last),
        .m_axis_tuser  (m_user),
        .frame_ok_o    (frame_ok),
        .frame_err_o   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect accepted output beats as {tuser, tlast, tdata} and count status pulses.
    always @(negedge clk) begin
        if (!arst_i) begin
            if (m_valid && m_ready) q.push_back({m_user, m_last, m_data});
            if (frame_ok)  ok_cnt++;
            if (frame_err) err_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] beat_at(input int i);
        return (q.size() > i) ? q[i] : 10'h3FF;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  done;
        n      = 0;
        done   = 1'b0;
        s_data = b;
        s_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 10000) begin
                $display("FAIL send_byte_stall observed=tready0 expected=tready1");
                $fatal(1, "input never accepted");
            end
        end
    endtask

    task automatic send_seq(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i]);
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        q.delete();
        ok_cnt  = 0;
        err_cnt = 0;
    endtask

    initial begin
        logic [7:0] bs[$];
        int         waited;

        arst_i  = 1'b1;
        s_data  = 8'h00;
        s_valid = 1'b0;
        m_ready = 1'b1;
        #12;
        chk("reset_tready", 32'(s_ready), 32'd0);
        chk("reset_tvalid", 32'(m_valid), 32'd0);
        idle(2);
        arst_i = 1'b0;
        #1;
        chk("post_reset_tready", 32'(s_ready), 32'd1);
        chk("post_reset_out", {21'd0, m_user, m_last, m_valid, m_data}, 32'd0);
        chk("post_reset_pulses", {30'd0, frame_ok, frame_err}, 32'd0);

        // Good frame preceded by junk
        clear_counts();
        bs = {8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_seq(bs);
        idle(5);
        chk("good_count", 32'(q.size()), 32'd3);
        chk("good_b0", 32'(beat_at(0)), 32'h011);
        chk("good_b1", 32'(beat_at(1)), 32'h022);
        chk("good_b2", 32'(beat_at(2)), 32'h133);
        chk("good_pulses", {ok_cnt[15:0], err_cnt[15:0]}, {16'd1, 16'd0});

        // Bad checksum
        clear_counts();
        bs = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        send_seq(bs);
        idle(5);
        chk("badchk_count", 32'(q.size()), 32'd3);
        chk("badchk_b1", 32'(beat_at(1)), 32'h022);
        chk("badchk_b2", 32'(beat_at(2)), 32'h333);
        chk("badchk_pulses", {ok_cnt[15:0], err_cnt[15:0]}, {16'd0, 16'd1});

        // Zero length, then a one-byte frame
        clear_counts();
        bs = {8'hA5, 8'h00};
        send_seq(bs);
        idle(3);
        chk("len0_err", 32'(err_cnt), 32'd1);
        chk("len0_no_out", 32'(q.size()), 32'd0);
        bs = {8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_seq(bs);
        idle(5);
        chk("len1_count", 32'(q.size()), 32'd1);
        chk("len1_b0", 32'(beat_at(0)), 32'h17E);
        chk("len1_ok", 32'(ok_cnt), 32'd1);

        // Timeout mid-payload
        clear_counts();
        bs = {8'hA5, 8'h03, 8'h11, 8'h22};
        send_seq(bs);
        waited = 0;
        while (err_cnt == 0 && waited < 6000) begin
            @(posedge clk);
            waited++;
        end
        #1;
        chk("to_window", 32'(waited > 4600 && waited < 4720), 32'd1);
        idle(4);
        chk("to_err", 32'(err_cnt), 32'd1);
        chk("to_count", 32'(q.size()), 32'd2);
        chk("to_b0", 32'(beat_at(0)), 32'h011);
        chk("to_b1", 32'(beat_at(1)), 32'h322);
        chk("to_hunt_tready", 32'(s_ready), 32'd1);
        clear_counts();
        bs = {8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_seq(bs);
        idle(5);
        chk("to_next_b0", 32'(beat_at(0)), 32'h17E);
        chk("to_next_pulses", {ok_cnt[15:0], err_cnt[15:0], 16'(q.size())}, {16'd1, 16'd0, 16'd1});

        // Downstream stall for 50 cycles while streaming
        clear_counts();
        m_ready = 1'b0;
        bs = {8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h04};
        fork
            send_seq(bs);
            begin
                repeat (30) @(posedge clk);
                @(negedge clk);
                chk("stall_tready_low", {30'd0, s_valid, s_ready}, 32'h2);
                repeat (20) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        idle(6);
        chk("stall_count", 32'(q.size()), 32'd5);
        chk("stall_b0", 32'(beat_at(0)), 32'h001);
        chk("stall_b2", 32'(beat_at(2)), 32'h003);
        chk("stall_b4", 32'(beat_at(4)), 32'h105);
        chk("stall_pulses", {ok_cnt[15:0], err_cnt[15:0]}, {16'd1, 16'd0});

        // Reset mid-frame with a beat parked in the output register
        clear_counts();
        m_ready = 1'b0;
        bs = {8'hA5, 8'h03, 8'h11, 8'h22};
        send_seq(bs);
        idle(2);
        chk("prerst_tvalid", 32'(m_valid), 32'd1);
        arst_i = 1'b1;
        #1;
        chk("rst_out_zero", {21'd0, m_user, m_last, m_valid, m_data}, 32'd0);
        chk("rst_tready", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        arst_i  = 1'b0;
        m_ready = 1'b1;
        clear_counts();
        bs = {8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_seq(bs);
        idle(5);
        chk("rst_after_count", 32'(q.size()), 32'd1);
        chk("rst_after_b0", 32'(beat_at(0)), 32'h17E);
        chk("rst_after_pulses", {ok_cnt[15:0], err_cnt[15:0]}, {16'd1, 16'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
